// File: rtl/lmsm_pkg.sv
// Shared types and widths for the LM/SM register-list sequencer.
// The list is fixed at 8 registers for this ISA, so the index is 3 bits.
package lmsm_pkg;

  localparam int LIST_W  = 8;
  localparam int IDX_W   = 3;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [LIST_W-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return LIST_W'(1) << idx;
  endfunction

endpackage

// File: rtl/lmsm_sequencer_lsb_encoder.sv
// Lowest-set-bit priority encoder over the register list.
// An all-zero input reports none_o=1 with idx_o=0.
module lsb_encoder
  import lmsm_pkg::*;
(
  input  logic [LIST_W-1:0] vec_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              none_o
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o  = IDX_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the latched register list lowest bit first and
// presents one register/address transfer per datapath handshake.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LIST_W-1:0]  imm8,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               abort,
  input  logic               xfer_ack,
  output logic               xfer_valid,
  output logic [IDX_W-1:0]   reg_idx,
  output logic [ADDR_W-1:0]  xfer_addr,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] xfer_count
);

  state_e              state_q;
  logic [LIST_W-1:0]   mask_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [COUNT_W-1:0]  count_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  logic [IDX_W-1:0]    lsb_idx;
  logic                lsb_none;
  logic [LIST_W-1:0]   mask_d;

  lsb_encoder u_lsb_encoder (
    .vec_i  (mask_q),
    .idx_o  (lsb_idx),
    .none_o (lsb_none)
  );

  assign mask_d = mask_q & ~idx_onehot(lsb_idx);

  // Abort outranks every other input; done is a pulse and self-clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        mask_q  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mask_q  <= imm8;
              addr_q  <= base_addr;
              count_q <= '0;
              busy_q  <= 1'b1;
              if (imm8 == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= XFER;
                valid_q <= 1'b1;
              end
            end
          end
          XFER: begin
            // An empty mask here can only follow a corrupted list; finish cleanly.
            if (lsb_none) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (xfer_ack) begin
              mask_q  <= mask_d;
              addr_q  <= addr_q + ADDR_W'(1);
              count_q <= count_q + COUNT_W'(1);
              if (mask_d == '0) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            mask_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign xfer_valid = valid_q;
  assign reg_idx    = lsb_idx;
  assign xfer_addr  = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: inputs change and outputs are
// sampled on the falling edge, expected values are hand-computed.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imm8;
  logic [15:0] base_addr;
  logic        abort;
  logic        xfer_ack;
  logic        xfer_valid;
  logic [2:0]  reg_idx;
  logic [15:0] xfer_addr;
  logic        busy;
  logic        done;
  logic [3:0]  xfer_count;

  int checks = 0;
  int fails  = 0;

  lmsm_sequencer #(.ADDR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imm8       (imm8),
    .base_addr  (base_addr),
    .abort      (abort),
    .xfer_ack   (xfer_ack),
    .xfer_valid (xfer_valid),
    .reg_idx    (reg_idx),
    .xfer_addr  (xfer_addr),
    .busy       (busy),
    .done       (done),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; imm8 = '0; base_addr = '0; abort = 1'b0; xfer_ack = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({xfer_valid, reg_idx, xfer_addr, busy, done, xfer_count} !== 26'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got valid=%b idx=%0d addr=%h busy=%b done=%b cnt=%0d, expected all zero",
               xfer_valid, reg_idx, xfer_addr, busy, done, xfer_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty_list();
    start = 1'b1; imm8 = 8'h00; base_addr = 16'h0040;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_valid !== 1'b0 || busy !== 1'b1 || xfer_count !== 4'd0) begin
      fails++;
      $display("[TB] FAIL empty_done: got done=%b valid=%b busy=%b cnt=%0d, expected done=1 valid=0 busy=1 cnt=0",
               done, xfer_valid, busy, xfer_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || xfer_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL empty_idle: got done=%b busy=%b valid=%b, expected 0 0 0", done, busy, xfer_valid);
    end
  endtask

  task automatic test_list_a5();
    int expIdx [4] = '{0, 2, 5, 7};
    start = 1'b1; imm8 = 8'hA5; base_addr = 16'h0100; xfer_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xfer_valid !== 1'b1 || done !== 1'b0 || reg_idx !== 3'(expIdx[i]) || xfer_addr !== 16'h0100 + 16'(i)) begin
        fails++;
        $display("[TB] FAIL a5_xfer%0d: got valid=%b done=%b idx=%0d addr=%h, expected valid=1 done=0 idx=%0d addr=%h",
                 i, xfer_valid, done, reg_idx, xfer_addr, expIdx[i], 16'h0100 + 16'(i));
      end
      @(negedge clk);
    end
    xfer_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_valid !== 1'b0 || xfer_count !== 4'd4) begin
      fails++;
      $display("[TB] FAIL a5_done: got done=%b valid=%b cnt=%0d, expected done=1 valid=0 cnt=4", done, xfer_valid, xfer_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || xfer_count !== 4'd4) begin
      fails++;
      $display("[TB] FAIL a5_idle: got done=%b busy=%b cnt=%0d, expected done=0 busy=0 cnt=4", done, busy, xfer_count);
    end
  endtask

  task automatic test_stall();
    start = 1'b1; imm8 = 8'h81; base_addr = 16'h0200; xfer_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (xfer_valid !== 1'b1 || reg_idx !== 3'd0 || xfer_addr !== 16'h0200 || xfer_count !== 4'd0) begin
        fails++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b idx=%0d addr=%h cnt=%0d, expected valid=1 idx=0 addr=0200 cnt=0",
                 i, xfer_valid, reg_idx, xfer_addr, xfer_count);
      end
      @(negedge clk);
    end
    xfer_ack = 1'b1;
    @(negedge clk);
    xfer_ack = 1'b0;
    checks++;
    if (xfer_valid !== 1'b1 || reg_idx !== 3'd7 || xfer_addr !== 16'h0201 || xfer_count !== 4'd1) begin
      fails++;
      $display("[TB] FAIL stall_second: got valid=%b idx=%0d addr=%h cnt=%0d, expected valid=1 idx=7 addr=0201 cnt=1",
               xfer_valid, reg_idx, xfer_addr, xfer_count);
    end
    @(negedge clk);
    checks++;
    if (xfer_valid !== 1'b1 || reg_idx !== 3'd7 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_hold_second: got valid=%b idx=%0d done=%b, expected valid=1 idx=7 done=0", xfer_valid, reg_idx, done);
    end
    xfer_ack = 1'b1;
    @(negedge clk);
    xfer_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_count !== 4'd2) begin
      fails++;
      $display("[TB] FAIL stall_done: got done=%b cnt=%0d, expected done=1 cnt=2", done, xfer_count);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    start = 1'b1; imm8 = 8'h03; base_addr = 16'hFFFF; xfer_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (reg_idx !== 3'd0 || xfer_addr !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL wrap_first: got idx=%0d addr=%h, expected idx=0 addr=ffff", reg_idx, xfer_addr);
    end
    @(negedge clk);
    checks++;
    if (reg_idx !== 3'd1 || xfer_addr !== 16'h0000 || xfer_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_second: got idx=%0d addr=%h valid=%b, expected idx=1 addr=0000 valid=1", reg_idx, xfer_addr, xfer_valid);
    end
    @(negedge clk);
    xfer_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_count !== 4'd2) begin
      fails++;
      $display("[TB] FAIL wrap_done: got done=%b cnt=%0d, expected done=1 cnt=2", done, xfer_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sequence();
    start = 1'b1; imm8 = 8'hFF; base_addr = 16'h0300; xfer_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++;
    if (reg_idx !== 3'd3 || xfer_addr !== 16'h0303 || xfer_count !== 4'd3) begin
      fails++;
      $display("[TB] FAIL midreset_pre: got idx=%0d addr=%h cnt=%0d, expected idx=3 addr=0303 cnt=3", reg_idx, xfer_addr, xfer_count);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({xfer_valid, reg_idx, xfer_addr, busy, done, xfer_count} !== 26'd0) begin
      fails++;
      $display("[TB] FAIL midreset_async: got valid=%b idx=%0d addr=%h busy=%b done=%b cnt=%0d, expected all zero",
               xfer_valid, reg_idx, xfer_addr, busy, done, xfer_count);
    end
    xfer_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || xfer_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_nodone: got done=%b valid=%b busy=%b, expected 0 0 0", done, xfer_valid, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1; imm8 = 8'hFF; base_addr = 16'h0300; xfer_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (xfer_valid !== 1'b1 || reg_idx !== 3'(i) || xfer_addr !== 16'h0300 + 16'(i) || xfer_count !== 4'(i)) begin
        fails++;
        $display("[TB] FAIL rerun_xfer%0d: got valid=%b idx=%0d addr=%h cnt=%0d, expected valid=1 idx=%0d addr=%h cnt=%0d",
                 i, xfer_valid, reg_idx, xfer_addr, xfer_count, i, 16'h0300 + 16'(i), i);
      end
      @(negedge clk);
    end
    xfer_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_count !== 4'd8) begin
      fails++;
      $display("[TB] FAIL rerun_done: got done=%b cnt=%0d, expected done=1 cnt=8", done, xfer_count);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; imm8 = 8'h0F; base_addr = 16'h0400; xfer_ack = 1'b1;
    @(negedge clk);
    imm8 = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xfer_valid !== 1'b1 || reg_idx !== 3'(i) || xfer_addr !== 16'h0400 + 16'(i)) begin
        fails++;
        $display("[TB] FAIL restart_ignored%0d: got valid=%b idx=%0d addr=%h, expected valid=1 idx=%0d addr=%h",
                 i, xfer_valid, reg_idx, xfer_addr, i, 16'h0400 + 16'(i));
      end
      @(negedge clk);
    end
    start = 1'b0; xfer_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_count !== 4'd4) begin
      fails++;
      $display("[TB] FAIL restart_done: got done=%b cnt=%0d, expected done=1 cnt=4", done, xfer_count);
    end
    @(negedge clk);

    // Second pass: cancel the same list partway through.
    start = 1'b1; imm8 = 8'h0F; base_addr = 16'h0400; xfer_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (reg_idx !== 3'd2 || xfer_count !== 4'd2) begin
      fails++;
      $display("[TB] FAIL abort_pre: got idx=%0d cnt=%0d, expected idx=2 cnt=2", reg_idx, xfer_count);
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; xfer_ack = 1'b0;
    checks++;
    if (xfer_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || xfer_count !== 4'd2) begin
      fails++;
      $display("[TB] FAIL abort_idle: got valid=%b busy=%b done=%b cnt=%0d, expected valid=0 busy=0 done=0 cnt=2",
               xfer_valid, busy, done, xfer_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || xfer_valid !== 1'b0 || xfer_count !== 4'd2) begin
      fails++;
      $display("[TB] FAIL abort_nodone: got done=%b valid=%b cnt=%0d, expected done=0 valid=0 cnt=2", done, xfer_valid, xfer_count);
    end
  endtask

  initial begin
    test_reset();
    test_empty_list();
    test_list_a5();
    test_stall();
    test_addr_wrap();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Register-list sequencer for the multicycle core's LM/SM (load/store multiple) instructions. Latches the 8-bit register-list immediate and a base address, then issues one register transfer per handshake: lowest set bit first, ascending addresses. Each issued index is the `position` consumed by the bit-clearing stage that follows. Sits between the main control FSM and the register-file/memory datapath.

## Interface
- `ADDR_W`, 16: memory address width.
- `LIST_W`, 8: register-list width; fixed at 8 for this ISA, so the index is 3 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: begin a sequence; sampled only in IDLE.
- `imm8` input LIST_W: register list; bit i set means transfer register Ri.
- `base_addr` input ADDR_W: address of the first transfer.
- `abort` input 1: synchronous cancel; returns to IDLE with no `done`.
- `xfer_ack` input 1: datapath accepted the current transfer.
- `xfer_valid` output 1: a transfer is presented.
- `reg_idx` output 3: register index of the current transfer.
- `xfer_addr` output ADDR_W: memory address of the current transfer.
- `busy` output 1: high in XFER and DONE.
- `done` output 1: one-cycle pulse at end of sequence.
- `xfer_count` output 4: transfers completed in this sequence, 0–8.

## Operation
- States: IDLE, XFER, DONE.
- IDLE, `start`=1:
  - latch mask←`imm8`, addr←`base_addr`, count←0;
  - if `imm8`==0, go to DONE; otherwise go to XFER.
- IDLE, `start`=0: remain in IDLE.
- XFER outputs:
  - `xfer_valid`=1;
  - `reg_idx` = index of the lowest set bit of mask;
  - `xfer_addr` = addr.
- XFER, `xfer_ack`=1 at the edge:
  - clear mask[reg_idx]; addr←addr+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000); count←count+1;
  - if the cleared mask is zero, go to DONE; otherwise stay in XFER.
- XFER, `xfer_ack`=0: hold all state and outputs stable.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `xfer_count` holds its final value until the next accepted `start`.
- `abort` has priority over `xfer_ack` and `start`. From any state, `abort` goes to IDLE, clears mask, and produces no `done`. `xfer_count` keeps the partial value.
- `start` is ignored while `busy`.
- `reg_idx` and `xfer_addr` are valid only while `xfer_valid`=1. Otherwise they show the registered values, which are stable and must not be relied on.
- Reset values: state IDLE, mask 0, addr 0, count 0. Outputs: `xfer_valid`=0, `reg_idx`=0, `xfer_addr`=0, `busy`=0, `done`=0, `xfer_count`=0.
- Reset asserted mid-sequence abandons the sequence immediately; `done` is not issued.

## Timing
- Outputs depend only on registered state. There is no combinational path from inputs to outputs.
- Latency: `start` accepted at edge N gives `xfer_valid` high in cycle N+1 (non-empty list), or `done` high in cycle N+1 (empty list).
- With `xfer_ack` held high, one transfer completes per cycle. A list of k set bits gives `done` in cycle N+k+1.
- `done` and `xfer_valid` are never high in the same cycle.
- Earliest next `start` is accepted at the edge that ends the `done` cycle plus one (IDLE), so sequences are separated by at least one idle cycle.

## Structure
- Package `lmsm_pkg`:
  - state enum (IDLE, XFER, DONE);
  - `LIST_W`=8 and index width 3.
- Sub-module `lsb_encoder`: combinational lowest-set-bit priority encoder (8→3, plus a `none` flag). It is instantiated once on the mask register.
- Keep the encoder separate; the control FSM reuses it for list-empty checks.

## Test plan
- `imm8`=0x00, `base_addr`=0x0040, `start` → no `xfer_valid`; `done` in the next cycle; `xfer_count`=0.
- `imm8`=0xA5, `base_addr`=0x0100, `xfer_ack` tied high → (`reg_idx`,`xfer_addr`) = (0,0x0100), (2,0x0101), (5,0x0102), (7,0x0103) on consecutive cycles; `done` one cycle later; `xfer_count`=4.
- `imm8`=0x81, `xfer_ack` low for 3 cycles, then pulsed → `reg_idx`=0 and `xfer_addr` held stable during the stall; then `reg_idx`=7; exactly 2 transfers.
- `imm8`=0x03, `base_addr`=0xFFFF → addresses 0xFFFF then 0x0000.
- `imm8`=0xFF, async `reset` low after the 3rd ack → all outputs at reset values immediately; no `done`. After release, a new `start` runs cleanly from the 0xFF list.
- `imm8`=0x0F, `start` re-asserted with `imm8`=0xF0 during XFER → ignored, indices 0–3 issued. Then `abort` after the 2nd ack → IDLE, no `done`, `xfer_count`=2.
